// File: rtl/sb_pkg.sv
// Shared constants and payload type for the writeback arbiter / scoreboard slice.
package sb_pkg;

    localparam int unsigned REG_ADDR_W  = 5;
    localparam int unsigned NUM_REGS    = 32;
    localparam int unsigned DEF_NUM_REQ = 3;
    localparam int unsigned DEF_XLEN    = 32;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] rd;
        logic [DEF_XLEN-1:0]   data;
    } wb_req_t;

endpackage

// File: rtl/wb_arbiter.sv
// One-hot grant over the writeback requesters.
// Fixed priority (index 0 highest) by default; round-robin when RR_ARB_EN is defined.
module wb_arbiter #(
    parameter int unsigned NUM_REQ = 3
) (
`ifdef RR_ARB_EN
    input  logic               clk,
    input  logic               rst,
`endif
    input  logic [NUM_REQ-1:0] req,
    output logic [NUM_REQ-1:0] grant
);

    localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

`ifdef RR_ARB_EN
    logic [IDX_W-1:0] ptr;
    logic [IDX_W-1:0] idx;
    logic [IDX_W-1:0] win;
    logic             found;

    // Search starts at the pointer and wraps around.
    always_comb begin
        grant = '0;
        idx   = '0;
        win   = '0;
        found = 1'b0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            idx = IDX_W'((32'(ptr) + i) % NUM_REQ);
            if (!found && req[idx]) begin
                found      = 1'b1;
                grant[idx] = 1'b1;
                win        = idx;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr <= '0;
        end else if (found) begin
            ptr <= (32'(win) == NUM_REQ - 1) ? '0 : win + IDX_W'(1);
        end
    end
`else
    logic found;

    always_comb begin
        grant = '0;
        found = 1'b0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (!found && req[i]) begin
                found    = 1'b1;
                grant[i] = 1'b1;
            end
        end
    end
`endif

endmodule

// File: rtl/wb_scoreboard_arb.sv
// Writeback arbitration onto the single register-file write port plus a busy scoreboard.
// Define RR_ARB_EN for round-robin arbitration instead of fixed priority.
module wb_scoreboard_arb
    import sb_pkg::*;
#(
    parameter int unsigned NUM_REQ = DEF_NUM_REQ,
    parameter int unsigned XLEN    = DEF_XLEN
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          issue_valid,
    input  logic [REG_ADDR_W-1:0]         issue_rs1,
    input  logic [REG_ADDR_W-1:0]         issue_rs2,
    input  logic [REG_ADDR_W-1:0]         issue_rd,
    input  logic                          issue_rd_we,
    output logic                          issue_stall,
    input  logic [NUM_REQ-1:0]            wb_valid,
    input  logic [NUM_REQ*REG_ADDR_W-1:0] wb_rd,
    input  logic [NUM_REQ*XLEN-1:0]       wb_data,
    output logic [NUM_REQ-1:0]            wb_ready,
    output logic                          rf_we,
    output logic [REG_ADDR_W-1:0]         rf_rd_addr,
    output logic [XLEN-1:0]               rf_rd_data,
    output logic                          sb_empty
);

    logic [NUM_REQ-1:0]    grant;
    logic [NUM_REGS-1:0]   busy;
    logic [NUM_REGS-1:0]   busy_next;
    logic [REG_ADDR_W-1:0] sel_rd;
    logic [XLEN-1:0]       sel_data;
    logic                  any_grant;
    logic                  issue_set;

    wb_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_arb (
`ifdef RR_ARB_EN
        .clk     (clk),
        .rst     (rst),
`endif
        .req     (wb_valid),
        .grant   (grant)
    );

    assign wb_ready  = rst ? '0 : grant;
    assign any_grant = |wb_ready;

    // Mux the granted source's payload into the output stage.
    always_comb begin
        sel_rd   = '0;
        sel_data = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (wb_ready[i]) begin
                sel_rd   = wb_rd[i*REG_ADDR_W +: REG_ADDR_W];
                sel_data = wb_data[i*XLEN +: XLEN];
            end
        end
    end

    assign issue_stall = issue_valid &
                         (busy[issue_rs1] | busy[issue_rs2] | (issue_rd_we & busy[issue_rd]));
    assign issue_set   = issue_valid & ~issue_stall & issue_rd_we & (issue_rd != '0);
    assign sb_empty    = ~|busy;

    // Clear on the committed write, then set from issue so a same-cycle set wins.
    always_comb begin
        busy_next = busy;
        if (rf_we) begin
            busy_next[rf_rd_addr] = 1'b0;
        end
        if (issue_set) begin
            busy_next[issue_rd] = 1'b1;
        end
        busy_next[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy       <= '0;
            rf_we      <= 1'b0;
            rf_rd_addr <= '0;
            rf_rd_data <= '0;
        end else begin
            busy  <= busy_next;
            rf_we <= any_grant & (sel_rd != '0);
            if (any_grant) begin
                rf_rd_addr <= sel_rd;
                rf_rd_data <= sel_data;
            end
        end
    end

endmodule
